// File: rtl/prog_loader.sv
// prog_loader: loads a byte-framed program (A5, N, N big-endian words) into instruction memory
// while holding the CPU in reset. Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_wdata_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        error_o
);
  typedef enum logic [2:0] {
    IDLE, LEN, DATA, WRITE,
`ifdef PROG_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_e;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_e LAST = CHK;
`else
  localparam state_e LAST = DONE;
`endif
  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);
  state_e state_q, state_d;
  logic [31:0] addr_q, addr_d, asm_q, asm_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] bcnt_q, bcnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif
  logic acc;
  // Outputs are gated by reset so they read as reset values for the whole time reset is low.
  assign rx_ready_o   = rst_ni && state_q != WRITE;
  assign imem_we_o    = rst_ni && state_q == WRITE;
  assign cpu_reset_o  = !rst_ni || state_q != DONE;
  assign done_o       = rst_ni && state_q == DONE;
  assign error_o      = rst_ni && state_q == ERR;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = asm_q;
  assign acc          = rx_valid_i && rx_ready_o;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: if (acc && rx_data_i == 8'hA5) state_d = LEN;
      LEN: if (acc) begin
        state_d = (rx_data_i == 8'd0 || rx_data_i > MAX_N) ? ERR : DATA;
        cnt_d   = rx_data_i;
        addr_d  = BASE_ADDR;
        bcnt_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d   = '0;
`endif
      end
      DATA: if (acc) begin
        asm_d  = {asm_q[23:0], rx_data_i};
        bcnt_d = bcnt_q + 2'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
        chk_d  = chk_q ^ rx_data_i;
`endif
        if (bcnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        addr_d  = addr_q + 32'd4;
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q == 8'd1) ? LAST : DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (acc) state_d = (rx_data_i == chk_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      asm_q   <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: scoreboard bench for prog_loader; expected writes are queued as frames are sent
// and popped by a monitor on each imem_we pulse. Honours PROG_LOADER_CHECKSUM_EN.
module tb_prog_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int MAXW = 64;
  logic        clk_i = 0, rst_ni = 0, rx_valid_i = 0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_ready_o, imem_we_o, cpu_reset_o, done_o, error_o;
  logic [31:0] imem_addr_o, imem_wdata_o;
  logic [63:0] exp_q[$];
  logic [31:0] words[8];
  int vectors = 0, miscompares = 0;

  prog_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_ready_o(rx_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_wdata_o(imem_wdata_o), .cpu_reset_o(cpu_reset_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard monitor: every write must match the oldest queued expectation.
  always @(negedge clk_i) begin
    logic [63:0] e;
    if (rst_ni) begin
      vectors++;
      if (rx_ready_o !== !imem_we_o) begin
        miscompares++;
        $display("FAIL ready_vs_write: rx_ready=%b imem_we=%b, required rx_ready=!imem_we", rx_ready_o, imem_we_o);
      end
      if (imem_we_o === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: addr=%h data=%h, no write expected", imem_addr_o, imem_wdata_o);
        end else begin
          e = exp_q.pop_front();
          if ({imem_addr_o, imem_wdata_o} !== e) begin
            miscompares++;
            $display("FAIL write: got addr=%h data=%h, exp addr=%h data=%h", imem_addr_o, imem_wdata_o, e[63:32], e[31:0]);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid_i = 1;
    rx_data_i  = b;
    while (rx_ready_o !== 1'b1 && t < 20) begin tick(1); t++; end
    vectors++;
    if (t >= 20) begin
      miscompares++;
      $display("FAIL send_timeout: rx_ready=%b, required 1 within 20 cycles", rx_ready_o);
    end
    tick(1);
    rx_valid_i = 0;
  endtask

  task automatic send_frame(input int n, input bit gap, input bit bad_chk, input bit hdr);
    logic [7:0] c = '0, b;
    if (hdr) send_byte(8'hA5);
    if (gap) tick(1);
    send_byte(8'(n));
    for (int i = 0; i < n; i++) begin
      for (int j = 3; j >= 0; j--) begin
        b = words[i][8*j +: 8];
        c ^= b;
        if (gap) tick(1);
        send_byte(b);
      end
      exp_q.push_back({BASE + 32'(4 * i), words[i]});
      vectors++;
      if (imem_we_o !== 1'b1) begin
        miscompares++;
        $display("FAIL write_latency: imem_we=%b one cycle after 4th byte, required 1", imem_we_o);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    if (gap) tick(1);
    send_byte(bad_chk ? c ^ 8'h01 : c);
`else
    tick(1);
`endif
  endtask

  task automatic check_done(input string name);
    vectors++;
    if ({done_o, cpu_reset_o, error_o} !== 3'b100 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: done=%b cpu_reset=%b error=%b pending=%0d, required 1 0 0 0",
               name, done_o, cpu_reset_o, error_o, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_ni = 0;
    tick(2);
    vectors++;
    if ({rx_ready_o, imem_we_o, cpu_reset_o, done_o, error_o} !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_flags: ready/we/cpu_rst/done/err=%b, required 00100",
               {rx_ready_o, imem_we_o, cpu_reset_o, done_o, error_o});
    end
    vectors++;
    if (imem_addr_o !== BASE || imem_wdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h data=%h, required %h 0", imem_addr_o, imem_wdata_o, BASE);
    end
    rst_ni = 1;
    tick(1);
    vectors++;
    if (rx_ready_o !== 1'b1 || cpu_reset_o !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_after_reset: rx_ready=%b cpu_reset=%b, required 1 1", rx_ready_o, cpu_reset_o);
    end
  endtask

  task automatic test_single();
    words[0] = 32'h2010_0005;
    send_frame(1, 0, 0, 1);
    check_done("single_word_done");
  endtask

  task automatic test_restart();
    send_byte(8'hA5);
    vectors++;
    if (cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_header: cpu_reset=%b done=%b, required 1 0", cpu_reset_o, done_o);
    end
    words[0] = 32'hDEAD_BEEF;
    words[1] = 32'h0123_4567;
    send_frame(2, 0, 0, 0);
    check_done("restart_done");
  endtask

  task automatic test_gaps();
    words[0] = 32'hA1B2_C3D4;
    words[1] = 32'h0000_00FF;
    words[2] = 32'h8000_0001;
    send_frame(3, 1, 0, 1);
    check_done("gapped_frame_done");
  endtask

  task automatic test_bad_count();
    send_byte(8'hA5);
    send_byte(8'h00);
    vectors++;
    if (error_o !== 1'b1 || cpu_reset_o !== 1'b1 || done_o !== 1'b0) begin
      miscompares++;
      $display("FAIL count_zero: error=%b cpu_reset=%b done=%b, required 1 1 0", error_o, cpu_reset_o, done_o);
    end
    send_byte(8'h17);
    send_byte(8'hA5);
    vectors++;
    if (error_o !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear: error=%b after header, required 0", error_o);
    end
    send_byte(8'(MAXW + 1));
    tick(3);
    vectors++;
    if (error_o !== 1'b1 || cpu_reset_o !== 1'b1) begin
      miscompares++;
      $display("FAIL count_over: error=%b cpu_reset=%b, required 1 1", error_o, cpu_reset_o);
    end
    words[0] = 32'h5555_AAAA;
    send_frame(1, 0, 0, 1);
    check_done("after_error_done");
  endtask

  task automatic test_reset_mid();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    rst_ni = 0;
    tick(1);
    vectors++;
    if ({rx_ready_o, imem_we_o, cpu_reset_o, done_o, error_o} !== 5'b00100 ||
        imem_addr_o !== BASE || imem_wdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: flags=%b addr=%h data=%h, required 00100 %h 0",
               {rx_ready_o, imem_we_o, cpu_reset_o, done_o, error_o}, imem_addr_o, imem_wdata_o, BASE);
    end
    rst_ni = 1;
    tick(2);
    words[0] = 32'hCAFE_F00D;
    words[1] = 32'h1357_9BDF;
    send_frame(2, 0, 0, 1);
    check_done("post_reset_frame");
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_bad_checksum();
    words[0] = 32'h0F0F_0F0F;
    words[1] = 32'h1234_5678;
    send_frame(2, 0, 1, 1);
    vectors++;
    if ({error_o, done_o, cpu_reset_o} !== 3'b101 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bad_checksum: error=%b done=%b cpu_reset=%b pending=%0d, required 1 0 1 0",
               error_o, done_o, cpu_reset_o, exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_restart();
    test_gaps();
    test_bad_count();
    test_reset_mid();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_bad_checksum();
`endif
    tick(3);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_writes: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
